// File: rtl/soc_system_ctrl_out_pulse.sv
// Avalon-MM output port with set/clear/direct-write access.
// Adds a retriggerable shared one-shot, a sticky done flag and an irq.
module soc_system_ctrl_out_pulse #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned PULSE_LEN_RESET = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_SET    = 3'd1;
  localparam logic [2:0] A_CLR    = 3'd2;
  localparam logic [2:0] A_PULSE  = 3'd3;
  localparam logic [2:0] A_LEN    = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;
  localparam logic [2:0] A_IRQEN  = 3'd6;

  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] pulse_mask;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  pulse_len;
  logic                  done;
  logic                  irq_en;

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd;
  logic                  busy;
  logic                  pulse_wr;
  logic                  expire;
  logic                  done_clr;

  assign wr       = chipselect & ~write_n;
  assign wd       = writedata[DATA_WIDTH-1:0];
  assign busy     = |pulse_mask;
  assign pulse_wr = wr && (address == A_PULSE)
                    && (pulse_len != '0);
  // A PULSE write on the expiry edge wins over expiry.
  assign expire   = busy && (cnt == CNT_WIDTH'(1))
                    && !pulse_wr;
  assign done_clr = wr && (address == A_STATUS)
                    && writedata[1];

  assign out_port = data_out | pulse_mask;
  assign irq      = done & irq_en;

  // Output data register: direct, set and clear writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        A_DATA:  data_out <= wd;
        A_SET:   data_out <= data_out | wd;
        A_CLR:   data_out <= data_out & ~wd;
        default: data_out <= data_out;
      endcase
    end
  end

  // One-shot: load/retrigger, count down, expire.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_mask <= '0;
      cnt        <= '0;
    end else if (pulse_wr) begin
      pulse_mask <= pulse_mask | wd;
      cnt        <= pulse_len;
    end else if (expire) begin
      pulse_mask <= '0;
      cnt        <= '0;
    end else if (busy) begin
      cnt        <= cnt - CNT_WIDTH'(1);
    end
  end

  // Sticky done flag; a set on the same edge beats the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else if (expire) begin
      done <= 1'b1;
    end else if (done_clr) begin
      done <= 1'b0;
    end
  end

  // Pulse length and interrupt enable configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_len <= CNT_WIDTH'(PULSE_LEN_RESET);
      irq_en    <= 1'b0;
    end else if (wr) begin
      if (address == A_LEN)
        pulse_len <= writedata[CNT_WIDTH-1:0];
      if (address == A_IRQEN)
        irq_en    <= writedata[0];
    end
  end

  // Combinational zero-wait-state read mux.
  always_comb begin
    readdata = '0;
    unique case (address)
      A_DATA:   readdata = 32'(data_out);
      A_SET:    readdata = 32'(data_out);
      A_CLR:    readdata = 32'(data_out);
      A_PULSE:  readdata = 32'(pulse_mask);
      A_LEN:    readdata = 32'(pulse_len);
      A_STATUS: readdata = {30'd0, done, busy};
      A_IRQEN:  readdata = {31'd0, irq_en};
      3'd7:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_ctrl_out_pulse.sv
// Directed bench for soc_system_ctrl_out_pulse.
// Each scenario task drives vectors and checks hand-computed values.
module tb_soc_system_ctrl_out_pulse;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic        irq;

  int errors = 0;
  int checks = 0;

  soc_system_ctrl_out_pulse dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out_port !== 32'h0) begin
      errors++;
      $display("FAIL reset_out got %h exp %h", out_port, 32'h0);
    end
    rd(3'd4, d);
    checks++;
    if (d !== 32'd100) begin
      errors++;
      $display("FAIL reset_len got %0d exp 100", d);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got %b exp 0", irq);
    end
    wr(3'd0, 32'hA5A5_0000);
    checks++;
    if (out_port !== 32'hA5A5_0000) begin
      errors++;
      $display("FAIL data_out got %h exp a5a50000", out_port);
    end
    rd(3'd0, d);
    checks++;
    if (d !== 32'hA5A5_0000) begin
      errors++;
      $display("FAIL data_rd got %h exp a5a50000", d);
    end
  endtask

  task automatic test_set_clr;
    logic [31:0] d;
    wr(3'd0, 32'h0F);
    wr(3'd1, 32'h30);
    checks++;
    if (out_port !== 32'h3F) begin
      errors++;
      $display("FAIL set got %h exp 3f", out_port);
    end
    wr(3'd2, 32'h05);
    checks++;
    if (out_port !== 32'h3A) begin
      errors++;
      $display("FAIL clr got %h exp 3a", out_port);
    end
    wr(3'd7, 32'hFFFF_FFFF);
    checks++;
    if (out_port !== 32'h3A) begin
      errors++;
      $display("FAIL addr7_wr got %h exp 3a", out_port);
    end
    rd(3'd7, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL addr7_rd got %h exp 0", d);
    end
    rd(3'd2, d);
    checks++;
    if (d !== 32'h3A) begin
      errors++;
      $display("FAIL clr_rd got %h exp 3a", d);
    end
  endtask

  task automatic test_pulse;
    int n;
    logic [31:0] d;
    wr(3'd0, 32'h0);
    wr(3'd4, 32'd10);
    wr(3'd6, 32'h1);
    wr(3'd3, 32'h1);
    n = 0;
    while (out_port[0] && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL pulse_len got %0d exp 10", n);
    end
    rd(3'd5, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL pulse_status got %h exp 2", d);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL pulse_irq got %b exp 1", irq);
    end
    wr(3'd5, 32'h2);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clr got %b exp 0", irq);
    end
  endtask

  task automatic test_retrigger;
    int c0, c1, f0, f1, ci;
    c0 = 0; c1 = 0; f0 = -1; f1 = -1; ci = 0;
    wr(3'd4, 32'd8);
    address   = 3'd3;
    writedata = 32'h1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      c0 += int'(out_port[0]);
      c1 += int'(out_port[1]);
      ci += int'(irq);
      if (!out_port[0] && f0 < 0) f0 = i;
      if (!out_port[1] && f1 < 0 && c1 > 0) f1 = i;
      if (i == 4) begin
        writedata  = 32'h2;
        chipselect = 1'b1;
        write_n    = 1'b0;
      end else begin
        chipselect = 1'b0;
        write_n    = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (c0 !== 13) begin
      errors++;
      $display("FAIL retrig_b0 got %0d exp 13", c0);
    end
    checks++;
    if (c1 !== 8) begin
      errors++;
      $display("FAIL retrig_b1 got %0d exp 8", c1);
    end
    checks++;
    if (f0 !== f1) begin
      errors++;
      $display("FAIL retrig_fall got %0d exp %0d", f1, f0);
    end
    checks++;
    if (ci !== 7) begin
      errors++;
      $display("FAIL retrig_done got %0d exp 7", ci);
    end
    wr(3'd5, 32'h2);
  endtask

  task automatic test_boundary;
    int n;
    logic [31:0] d;
    wr(3'd4, 32'd0);
    wr(3'd3, 32'hF);
    checks++;
    if (out_port !== 32'h0) begin
      errors++;
      $display("FAIL len0_out got %h exp 0", out_port);
    end
    rd(3'd5, d);
    checks++;
    if (d[0] !== 1'b0) begin
      errors++;
      $display("FAIL len0_busy got %b exp 0", d[0]);
    end
    wr(3'd4, 32'd1);
    wr(3'd3, 32'h4);
    n = 0;
    while (out_port[2] && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL len1 got %0d exp 1", n);
    end
    wr(3'd5, 32'h2);
    wr(3'd4, 32'd3);
    wr(3'd3, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    wr(3'd3, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL exp_edge_done got %b exp 0", irq);
    end
    n = 3;
    while (out_port[0] && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL exp_edge_len got %0d exp 6", n);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL exp_edge_end got %b exp 1", irq);
    end
    wr(3'd5, 32'h2);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    wr(3'd0, 32'h3A00);
    wr(3'd4, 32'd50);
    wr(3'd3, 32'hFF);
    repeat (19) @(posedge clk);
    #1;
    checks++;
    if (out_port !== 32'h3AFF) begin
      errors++;
      $display("FAIL mid_active got %h exp 3aff", out_port);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out_port !== 32'h0) begin
      errors++;
      $display("FAIL mid_out got %h exp 0", out_port);
    end
    rd(3'd5, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL mid_status got %h exp 0", d);
    end
    rd(3'd4, d);
    checks++;
    if (d !== 32'd100) begin
      errors++;
      $display("FAIL mid_len got %0d exp 100", d);
    end
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0 || out_port !== 32'h0) begin
      errors++;
      $display("FAIL mid_after got %b/%h exp 0/0", irq, out_port);
    end
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    test_reset;
    test_set_clr;
    test_pulse;
    test_retrigger;
    test_boundary;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_system_ctrl_out_pulse.md
# soc_system_ctrl_out_pulse

Parametrised Avalon-MM output port for the HPS-to-fabric control path of the IGBT gate-drive logic. It replaces the fixed 32-bit single-register output port with set, clear and direct-write access to the output bits. It adds a retriggerable hardware one-shot that asserts selected bits for a programmed number of clock cycles, with a sticky done flag and an interrupt. It sits on the lightweight HPS bridge and drives the gate-control and enable lines.

## Interface
- DATA_WIDTH, 32: output bits; legal range 1..32.
- CNT_WIDTH, 16: width of the pulse-length counter; legal range 1..32.
- RESET_VALUE, 0: value of `data_out` after reset; DATA_WIDTH bits.
- PULSE_LEN_RESET, 100: value of `pulse_len` after reset.

Ports (clock and reset first):
- clk  in  1  system clock; the block has one clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational, zero wait states.
- out_port  out  DATA_WIDTH  `data_out | pulse_mask`.
- irq  out  1  `done & irq_en`.

## Operation
- Write qualifier `wr` = `chipselect & ~write_n`.
- Only `writedata[DATA_WIDTH-1:0]` is used for bit registers. Unused read bits return 0.

Register map (by address):
- 0 DATA
  - Read and write. A write loads `data_out`.
  - A read returns `data_out`.
- 1 SET
  - Write-1-to-set: `data_out |= wd`.
  - A read returns `data_out`.
- 2 CLR
  - Write-1-to-clear: `data_out &= ~wd`.
  - A read returns `data_out`.
- 3 PULSE
  - Write-1 bits start a pulse: `pulse_mask |= wd` and `cnt <= pulse_len`. This applies only if `pulse_len != 0`; otherwise the write is ignored.
  - A read returns `pulse_mask`.
- 4 LEN
  - Read and write. `pulse_len` is `writedata[CNT_WIDTH-1:0]`.
  - A write does not affect a pulse already running.
- 5 STATUS
  - bit0 = busy (`pulse_mask != 0`), read-only.
  - bit1 = done, sticky. Writing 1 to bit1 clears it.
- 6 IRQ_EN
  - bit0 = `irq_en`, read and write.
- 7: reads 0; writes are ignored.

One-shot:
- A single shared counter serves all bits.
- While busy, `cnt` decrements every cycle.
- On the edge where `cnt == 1` and no PULSE write occurs:
  - `pulse_mask <= 0`
  - `cnt <= 0`
  - `done <= 1`
- Retrigger: a PULSE write while busy ORs the new bits into `pulse_mask` and reloads `cnt`. All active bits end together.

Simultaneous events:
- PULSE write on the expiry edge: the write wins. The old mask is ORed with the new bits, `cnt` reloads and `done` is not set.
- `done` set and STATUS W1C on the same edge: the set wins.
- DATA, SET or CLR writes during a pulse change `data_out` only. The pulse mask is unaffected.

## Timing
- All state updates on the rising edge of `clk`.
- A write on edge k is visible on `out_port` and `readdata` after edge k, with one cycle of write latency.
- `readdata` follows `address` combinationally.
- Pulse of length N written on edge k:
  - Masked bits are high from edge k to edge k+N, exactly N cycles.
  - `done` and `irq` (if enabled) rise at edge k+N.
- Reset values:
  - `data_out` = RESET_VALUE, so `out_port` = RESET_VALUE.
  - `pulse_mask` = 0, `cnt` = 0, `done` = 0.
  - `irq_en` = 0, `irq` = 0.
  - `pulse_len` = PULSE_LEN_RESET.
- Reset during a pulse aborts it on the same edge. `done` is not set.
- Reset has priority over any write in the same cycle.

## Test plan
- Reset: after reset, `out_port` = 0, `readdata`@4 = 100, `irq` = 0. Then write DATA = 0xA5A5_0000 → `out_port` = 0xA5A5_0000 on the next cycle, and readback @0 matches.
- SET/CLR: DATA = 0x0F; SET 0x30 → 0x3F; CLR 0x05 → 0x3A. A write to address 7 leaves 0x3A.
- Pulse: LEN = 10, IRQ_EN = 1, PULSE 0x1 → bit0 high exactly 10 cycles. Then `done` = 1 and `irq` = 1. STATUS write 0x2 → `irq` = 0.
- Retrigger: LEN = 8, PULSE 0x1, then PULSE 0x2 after 5 cycles → bit0 high 13 cycles, bit1 high 8 cycles, both fall on the same edge, one `done`.
- Boundary: LEN = 0 with PULSE 0xF → no output change, busy = 0. LEN = 1 → a 1-cycle pulse. A PULSE write on the expiry edge → the mask stays high with no gap and `done` stays 0.
- Reset mid-pulse: LEN = 50, PULSE 0xFF, reset at cycle 20 → `out_port` = RESET_VALUE, busy = 0, `done` = 0.
